fu_scheduler: RTL
=================

FU_SCHEDULER -- requirements
Module: fu_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 64: max WAIT cycles before abort; legal range 2..255.
REQ-002 Parameter RES_W, default 24: functional-unit result width.
REQ-003 clk  in  1  single clock, all state on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_i  in  1  decode presents a functional-unit instruction.
REQ-006 flush_i  in  1  branch flush; cancels acceptance of req_i this cycle.
REQ-007 rd_i  in  5  destination register of request.
REQ-008 a_i, b_i  in  8 each  operands of request.
REQ-009 alu_we_i  in  1  pipeline register-file write in progress this cycle.
REQ-010 err_clr_i  in  1  clears sticky error.
REQ-011 fu_start_o  out  1  one-cycle start pulse to functional unit.
REQ-012 fu_a_o, fu_b_o  out  8 each  latched operands to functional unit.
REQ-013 fu_busy_i  in  1  functional unit busy.
REQ-014 fu_res_i  in  RES_W  functional-unit result.
REQ-015 freeze_o  out  1  stall fetch/decode.
REQ-016 wb_valid_o  out  1  write wb_data_o to wb_rd_o this cycle.
REQ-017 wb_rd_o  out  5; wb_data_o  out  32  writeback target and data.
REQ-018 err_o  out  1  sticky timeout flag.
REQ-019 ops_o  out  16  count of completed operations.

Function
REQ-020 FSM states IDLE, START, WAIT, WB; encodings fixed in shared header.
REQ-021 IDLE: req_i=1 and flush_i=0 -> latch rd_i, a_i, b_i; next START; otherwise stay.
REQ-022 freeze_o = (state!=IDLE) or (req_i and not flush_i), combinational.
REQ-023 START: fu_start_o=1 for exactly one cycle; wait counter cleared; next WAIT.
REQ-024 WAIT: counter increments each cycle; fu_busy_i ignored while counter==0 (unit arm cycle).
REQ-025 WAIT, counter>=1, fu_busy_i=0: capture fu_res_i zero-extended to 32 bits; next WB.
REQ-026 WAIT, counter==TIMEOUT-1, fu_busy_i=1: set err_o, no writeback, ops_o unchanged; next IDLE.
REQ-027 WB, alu_we_i=1: wb_valid_o=0, hold WB, freeze_o stays 1.
REQ-028 WB, alu_we_i=0: wb_valid_o=1 for one cycle if latched rd!=0, else 0; ops_o increments; next IDLE.
REQ-029 ops_o saturates at 0xFFFF.
REQ-030 fu_a_o/fu_b_o hold latched operands from START until next acceptance.
REQ-031 req_i and flush_i outside IDLE are ignored; in-flight op always completes or times out.
REQ-032 err_clr_i=1 clears err_o next cycle; simultaneous timeout wins (err_o set).
REQ-033 Minimum latency: accept cycle N -> fu_start_o at N+1 -> wb_valid_o at N+4.
REQ-034 wb_valid_o, fu_start_o never asserted in IDLE.

Reset
REQ-035 rst_n low, any state: state=IDLE; fu_start_o, wb_valid_o, err_o, ops_o, latched rd/a/b/result, counter = 0 immediately.
REQ-036 freeze_o during reset follows REQ-022 with state=IDLE; op aborted mid-flight produces no writeback.

Structure
REQ-037 State encodings, RES_W default and operand width constants live in shared header sr_cpu.vh.
REQ-038 Timeout counter is sub-module fu_timeout_counter (clear, enable, terminal-count output).

Verification
REQ-039 req_i=1, rd=5, a=3, b=4; fu_busy high 2 cycles then low, res=12 -> wb_valid at N+5, wb_rd=5, wb_data=0x0000000C, ops_o=1.
REQ-040 req_i=1 with flush_i=1 -> stays IDLE, no fu_start_o, freeze_o=0.
REQ-041 Result ready while alu_we_i=1 for 3 cycles -> wb_valid delayed 3 cycles, freeze_o held, data unchanged.
REQ-042 fu_busy_i stuck high, TIMEOUT=8 -> err_o=1 at START+9, freeze_o drops, no wb_valid; err_clr_i clears it.
REQ-043 rd_i=0, res=0xFFFFFF -> no wb_valid, ops_o increments, returns IDLE.
REQ-044 rst_n low during WAIT -> IDLE, all outputs 0, later fu_busy_i low produces no writeback.

Source files
------------

// File: rtl/fu_scheduler_pkg.sv
// rtl/fu_scheduler_pkg.sv - shared state encodings and widths for the FU scheduler
package fu_scheduler_pkg;

   localparam int unsigned RES_W_DEF = 24;  // default functional-unit result width
   localparam int unsigned OPND_W    = 8;   // operand width
   localparam int unsigned RD_W      = 5;   // register index width
   localparam int unsigned DATA_W    = 32;  // writeback data width
   localparam int unsigned CNT_W     = 8;   // wait counter width (TIMEOUT <= 255)
   localparam int unsigned OPS_W     = 16;  // completed-op counter width

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WB    = 2'd3
   } state_e;

endpackage

// File: rtl/fu_timeout_counter.sv
// rtl/fu_timeout_counter.sv - wait-cycle counter with clear, enable and terminal count
module fu_timeout_counter
   import fu_scheduler_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // next count: clear has priority over increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/fu_scheduler.sv
// rtl/fu_scheduler.sv - issues one multi-cycle FU op, waits with timeout, writes back
module fu_scheduler
   import fu_scheduler_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned RES_W   = RES_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_i,
   input  logic              flush_i,
   input  logic [RD_W-1:0]   rd_i,
   input  logic [OPND_W-1:0] a_i,
   input  logic [OPND_W-1:0] b_i,
   input  logic              alu_we_i,
   input  logic              err_clr_i,
   output logic              fu_start_o,
   output logic [OPND_W-1:0] fu_a_o,
   output logic [OPND_W-1:0] fu_b_o,
   input  logic              fu_busy_i,
   input  logic [RES_W-1:0]  fu_res_i,
   output logic              freeze_o,
   output logic              wb_valid_o,
   output logic [RD_W-1:0]   wb_rd_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              err_o,
   output logic [OPS_W-1:0]  ops_o
);

   state_e              state_q, state_d;
   logic [RD_W-1:0]     rd_q, rd_d;
   logic [OPND_W-1:0]   a_q, a_d;
   logic [OPND_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic                err_q, err_d;
   logic [OPS_W-1:0]    ops_q, ops_d;

   logic                cnt_clr;
   logic                cnt_en;
   logic [CNT_W-1:0]    cnt;
   logic                cnt_tc;

   fu_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .cnt_o (cnt),
      .tc_o  (cnt_tc)
   );

   // next state, latches and pulses; the first WAIT cycle ignores busy while the unit arms
   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      err_d      = err_q;
      ops_d      = ops_q;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      fu_start_o = 1'b0;
      wb_valid_o = 1'b0;

      if (err_clr_i) begin
         err_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_i && !flush_i) begin
               rd_d    = rd_i;
               a_d     = a_i;
               b_d     = b_i;
               state_d = ST_START;
            end
         end
         ST_START: begin
            fu_start_o = 1'b1;
            cnt_clr    = 1'b1;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_en = 1'b1;
            if ((cnt != '0) && !fu_busy_i) begin
               res_d   = DATA_W'(fu_res_i);
               state_d = ST_WB;
            end else if (cnt_tc && fu_busy_i) begin
               err_d   = 1'b1;  // a timeout outranks a same-cycle clear
               state_d = ST_IDLE;
            end
         end
         ST_WB: begin
            if (!alu_we_i) begin
               wb_valid_o = (rd_q != '0);
               if (ops_q != '1) begin
                  ops_d = ops_q + 1'b1;
               end
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         ops_q   <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         err_q   <= err_d;
         ops_q   <= ops_d;
      end
   end

   assign freeze_o  = (state_q != ST_IDLE) || (req_i && !flush_i);
   assign fu_a_o    = a_q;
   assign fu_b_o    = b_q;
   assign wb_rd_o   = rd_q;
   assign wb_data_o = res_q;
   assign err_o     = err_q;
   assign ops_o     = ops_q;

endmodule
